// File: rtl/rs_if.sv
`default_nettype none
// ============================================================================
// Module   : rs_if
// Brief    : Dispatch, CDB and issue bundle for the ALU reservation station.
// Revision : 1.0 - initial release
// ============================================================================
interface rs_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int OP_WIDTH   = 6
) ();
    logic                  dispatch_valid;
    logic [OP_WIDTH-1:0]   dispatch_op;
    logic [DATA_WIDTH-1:0] dispatch_vj;
    logic [DATA_WIDTH-1:0] dispatch_vk;
    logic                  dispatch_qj_busy;
    logic                  dispatch_qk_busy;
    logic [ROB_WIDTH-1:0]  dispatch_qj;
    logic [ROB_WIDTH-1:0]  dispatch_qk;
    logic [DATA_WIDTH-1:0] dispatch_imm;
    logic [ADDR_WIDTH-1:0] dispatch_PC;
    logic [ROB_WIDTH-1:0]  dispatch_rob_index;
    logic                  rs_full;

    logic                  alu_ready;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [ROB_WIDTH-1:0]  alu_rob_index;
    logic                  lsb_ready;
    logic [DATA_WIDTH-1:0] lsb_result;
    logic [ROB_WIDTH-1:0]  lsb_rob_index;

    logic                  rs_to_alu_ready;
    logic [OP_WIDTH-1:0]   rs_to_alu_op;
    logic [DATA_WIDTH-1:0] rs_to_alu_rs1;
    logic [DATA_WIDTH-1:0] rs_to_alu_rs2;
    logic [DATA_WIDTH-1:0] rs_to_alu_imm;
    logic [ADDR_WIDTH-1:0] rs_to_alu_PC;
    logic [ROB_WIDTH-1:0]  rs_to_alu_rob_index;

    modport master (
        output dispatch_valid, dispatch_op, dispatch_vj, dispatch_vk,
               dispatch_qj_busy, dispatch_qk_busy, dispatch_qj, dispatch_qk,
               dispatch_imm, dispatch_PC, dispatch_rob_index,
               alu_ready, alu_result, alu_rob_index,
               lsb_ready, lsb_result, lsb_rob_index,
        input  rs_full, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1,
               rs_to_alu_rs2, rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index
    );

    modport slave (
        input  dispatch_valid, dispatch_op, dispatch_vj, dispatch_vk,
               dispatch_qj_busy, dispatch_qk_busy, dispatch_qj, dispatch_qk,
               dispatch_imm, dispatch_PC, dispatch_rob_index,
               alu_ready, alu_result, alu_rob_index,
               lsb_ready, lsb_result, lsb_rob_index,
        output rs_full, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1,
               rs_to_alu_rs2, rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index
    );
endinterface
`default_nettype wire

// File: rtl/rs.sv
`default_nettype none
// ============================================================================
// Module   : rs
// Brief    : ALU reservation station; buffers instructions until operands are
//            captured from the CDB and issues one ready entry per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rs #(
    parameter int RS_SIZE    = 16,
    parameter int RS_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int OP_WIDTH   = 6
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic clr_in,
    rs_if.slave  bus
);
    logic [RS_SIZE-1:0]    r_busy;
    logic [RS_SIZE-1:0]    r_qj_busy;
    logic [RS_SIZE-1:0]    r_qk_busy;
    logic [OP_WIDTH-1:0]   r_op  [RS_SIZE];
    logic [DATA_WIDTH-1:0] r_vj  [RS_SIZE];
    logic [DATA_WIDTH-1:0] r_vk  [RS_SIZE];
    logic [ROB_WIDTH-1:0]  r_qj  [RS_SIZE];
    logic [ROB_WIDTH-1:0]  r_qk  [RS_SIZE];
    logic [DATA_WIDTH-1:0] r_imm [RS_SIZE];
    logic [ADDR_WIDTH-1:0] r_pc  [RS_SIZE];
    logic [ROB_WIDTH-1:0]  r_rob [RS_SIZE];

    logic                  r_out_ready;
    logic [OP_WIDTH-1:0]   r_out_op;
    logic [DATA_WIDTH-1:0] r_out_rs1;
    logic [DATA_WIDTH-1:0] r_out_rs2;
    logic [DATA_WIDTH-1:0] r_out_imm;
    logic [ADDR_WIDTH-1:0] r_out_pc;
    logic [ROB_WIDTH-1:0]  r_out_rob;

    logic [RS_SIZE-1:0]    w_ready_vec;
    logic                  w_full;
    logic                  w_free_found;
    logic [RS_WIDTH-1:0]   w_free_idx;
    logic                  w_issue_found;
    logic [RS_WIDTH-1:0]   w_issue_idx;
    logic [DATA_WIDTH-1:0] w_disp_vj;
    logic [DATA_WIDTH-1:0] w_disp_vk;
    logic                  w_disp_qj_busy;
    logic                  w_disp_qk_busy;

    assign w_ready_vec = r_busy & ~r_qj_busy & ~r_qk_busy;
    assign w_full      = &r_busy;

    // Descending scan so the last hit, i.e. the lowest index, wins.
    always_comb begin
        w_free_found  = 1'b0;
        w_free_idx    = '0;
        w_issue_found = 1'b0;
        w_issue_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = RS_WIDTH'(i);
            end
            if (w_ready_vec[i]) begin
                w_issue_found = 1'b1;
                w_issue_idx   = RS_WIDTH'(i);
            end
        end
    end

    // Capture a same-cycle CDB result for a pending operand at dispatch.
    always_comb begin
        w_disp_vj      = bus.dispatch_vj;
        w_disp_qj_busy = bus.dispatch_qj_busy;
        w_disp_vk      = bus.dispatch_vk;
        w_disp_qk_busy = bus.dispatch_qk_busy;
        if (bus.dispatch_qj_busy) begin
            if (bus.alu_ready && bus.dispatch_qj == bus.alu_rob_index) begin
                w_disp_vj      = bus.alu_result;
                w_disp_qj_busy = 1'b0;
            end else if (bus.lsb_ready && bus.dispatch_qj == bus.lsb_rob_index) begin
                w_disp_vj      = bus.lsb_result;
                w_disp_qj_busy = 1'b0;
            end
        end
        if (bus.dispatch_qk_busy) begin
            if (bus.alu_ready && bus.dispatch_qk == bus.alu_rob_index) begin
                w_disp_vk      = bus.alu_result;
                w_disp_qk_busy = 1'b0;
            end else if (bus.lsb_ready && bus.dispatch_qk == bus.lsb_rob_index) begin
                w_disp_vk      = bus.lsb_result;
                w_disp_qk_busy = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || clr_in) begin
            r_busy      <= '0;
            r_out_ready <= 1'b0;
            r_out_op    <= '0;
            r_out_rs1   <= '0;
            r_out_rs2   <= '0;
            r_out_imm   <= '0;
            r_out_pc    <= '0;
            r_out_rob   <= '0;
        end else if (rdy_in) begin
            r_out_ready <= 1'b0;

            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && r_qj_busy[i]) begin
                    if (bus.alu_ready && r_qj[i] == bus.alu_rob_index) begin
                        r_vj[i]      <= bus.alu_result;
                        r_qj_busy[i] <= 1'b0;
                    end else if (bus.lsb_ready && r_qj[i] == bus.lsb_rob_index) begin
                        r_vj[i]      <= bus.lsb_result;
                        r_qj_busy[i] <= 1'b0;
                    end
                end
                if (r_busy[i] && r_qk_busy[i]) begin
                    if (bus.alu_ready && r_qk[i] == bus.alu_rob_index) begin
                        r_vk[i]      <= bus.alu_result;
                        r_qk_busy[i] <= 1'b0;
                    end else if (bus.lsb_ready && r_qk[i] == bus.lsb_rob_index) begin
                        r_vk[i]      <= bus.lsb_result;
                        r_qk_busy[i] <= 1'b0;
                    end
                end
            end

            if (w_issue_found) begin
                r_busy[w_issue_idx] <= 1'b0;
                r_out_ready         <= 1'b1;
                r_out_op            <= r_op[w_issue_idx];
                r_out_rs1           <= r_vj[w_issue_idx];
                r_out_rs2           <= r_vk[w_issue_idx];
                r_out_imm           <= r_imm[w_issue_idx];
                r_out_pc            <= r_pc[w_issue_idx];
                r_out_rob           <= r_rob[w_issue_idx];
            end

            // The free slot is never the issuing slot, so both writes coexist.
            if (bus.dispatch_valid && w_free_found) begin
                r_busy[w_free_idx]    <= 1'b1;
                r_op[w_free_idx]      <= bus.dispatch_op;
                r_vj[w_free_idx]      <= w_disp_vj;
                r_vk[w_free_idx]      <= w_disp_vk;
                r_qj_busy[w_free_idx] <= w_disp_qj_busy;
                r_qk_busy[w_free_idx] <= w_disp_qk_busy;
                r_qj[w_free_idx]      <= bus.dispatch_qj;
                r_qk[w_free_idx]      <= bus.dispatch_qk;
                r_imm[w_free_idx]     <= bus.dispatch_imm;
                r_pc[w_free_idx]      <= bus.dispatch_PC;
                r_rob[w_free_idx]     <= bus.dispatch_rob_index;
            end
        end
    end

    assign bus.rs_full             = w_full;
    assign bus.rs_to_alu_ready     = r_out_ready;
    assign bus.rs_to_alu_op        = r_out_op;
    assign bus.rs_to_alu_rs1       = r_out_rs1;
    assign bus.rs_to_alu_rs2       = r_out_rs2;
    assign bus.rs_to_alu_imm       = r_out_imm;
    assign bus.rs_to_alu_PC        = r_out_pc;
    assign bus.rs_to_alu_rob_index = r_out_rob;

endmodule
`default_nettype wire

// File: tb/tb_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs
// Brief    : Directed self-checking bench for the ALU reservation station.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs;
    localparam logic [5:0] c_OP_ADD = 6'd0;
    localparam logic [5:0] c_OP_SUB = 6'd1;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    logic clr_in = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    rs_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ROB_WIDTH(4), .OP_WIDTH(6)) bus ();

    rs #(.RS_SIZE(16), .RS_WIDTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(32),
         .ROB_WIDTH(4), .OP_WIDTH(6)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clr_in (clr_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick;
        @(negedge clk_in);
    endtask

    task automatic idle;
        bus.dispatch_valid     = 1'b0;
        bus.dispatch_op        = '0;
        bus.dispatch_vj        = '0;
        bus.dispatch_vk        = '0;
        bus.dispatch_qj_busy   = 1'b0;
        bus.dispatch_qk_busy   = 1'b0;
        bus.dispatch_qj        = '0;
        bus.dispatch_qk        = '0;
        bus.dispatch_imm       = '0;
        bus.dispatch_PC        = '0;
        bus.dispatch_rob_index = '0;
        bus.alu_ready          = 1'b0;
        bus.alu_result         = '0;
        bus.alu_rob_index      = '0;
        bus.lsb_ready          = 1'b0;
        bus.lsb_result         = '0;
        bus.lsb_rob_index      = '0;
    endtask

    task automatic drive_dispatch(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                  input logic qjb, input logic [3:0] qj, input logic qkb,
                                  input logic [3:0] qk, input logic [31:0] imm,
                                  input logic [31:0] pc, input logic [3:0] rob);
        bus.dispatch_valid     = 1'b1;
        bus.dispatch_op        = op;
        bus.dispatch_vj        = vj;
        bus.dispatch_vk        = vk;
        bus.dispatch_qj_busy   = qjb;
        bus.dispatch_qj        = qj;
        bus.dispatch_qk_busy   = qkb;
        bus.dispatch_qk        = qk;
        bus.dispatch_imm       = imm;
        bus.dispatch_PC        = pc;
        bus.dispatch_rob_index = rob;
    endtask

    task automatic test_reset;
        idle();
        rst_in = 1'b1;
        tick(); tick();
        rst_in = 1'b0;
        n_checks++; if (bus.rs_to_alu_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", bus.rs_to_alu_ready); end
        n_checks++; if (bus.rs_full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b expected 0", bus.rs_full); end
        n_checks++; if (bus.rs_to_alu_rs1 !== 32'h0) begin n_errors++; $display("FAIL reset_rs1: got %h expected 0", bus.rs_to_alu_rs1); end
        n_checks++; if (bus.rs_to_alu_rob_index !== 4'h0) begin n_errors++; $display("FAIL reset_rob: got %h expected 0", bus.rs_to_alu_rob_index); end
    endtask

    task automatic test_ready_dispatch;
        drive_dispatch(c_OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 32'h10, 32'h400, 4'd3);
        tick();
        idle();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b0) begin n_errors++; $display("FAIL rd_early: got %b expected 0", bus.rs_to_alu_ready); end
        tick();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b1) begin n_errors++; $display("FAIL rd_ready: got %b expected 1", bus.rs_to_alu_ready); end
        n_checks++; if (bus.rs_to_alu_rs1 !== 32'd5) begin n_errors++; $display("FAIL rd_rs1: got %h expected 5", bus.rs_to_alu_rs1); end
        n_checks++; if (bus.rs_to_alu_rs2 !== 32'd7) begin n_errors++; $display("FAIL rd_rs2: got %h expected 7", bus.rs_to_alu_rs2); end
        n_checks++; if (bus.rs_to_alu_op !== c_OP_ADD) begin n_errors++; $display("FAIL rd_op: got %h expected %h", bus.rs_to_alu_op, c_OP_ADD); end
        n_checks++; if (bus.rs_to_alu_rob_index !== 4'd3) begin n_errors++; $display("FAIL rd_rob: got %h expected 3", bus.rs_to_alu_rob_index); end
        n_checks++; if (bus.rs_to_alu_imm !== 32'h10) begin n_errors++; $display("FAIL rd_imm: got %h expected 10", bus.rs_to_alu_imm); end
        n_checks++; if (bus.rs_to_alu_PC !== 32'h400) begin n_errors++; $display("FAIL rd_pc: got %h expected 400", bus.rs_to_alu_PC); end
        tick();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b0) begin n_errors++; $display("FAIL rd_pulse: got %b expected 0", bus.rs_to_alu_ready); end
        n_checks++; if (bus.rs_to_alu_rs1 !== 32'd5) begin n_errors++; $display("FAIL rd_hold: got %h expected 5", bus.rs_to_alu_rs1); end
    endtask

    task automatic test_wakeup;
        drive_dispatch(c_OP_SUB, 32'hFFFF, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 32'h0, 32'h404, 4'd5);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (bus.rs_to_alu_ready !== 1'b0) begin n_errors++; $display("FAIL wk_wait%0d: got %b expected 0", k, bus.rs_to_alu_ready); end
            tick();
        end
        bus.alu_ready = 1'b1; bus.alu_rob_index = 4'd2; bus.alu_result = 32'd10;
        tick();
        idle();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b0) begin n_errors++; $display("FAIL wk_bcast_cycle: got %b expected 0", bus.rs_to_alu_ready); end
        tick();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b1) begin n_errors++; $display("FAIL wk_ready: got %b expected 1", bus.rs_to_alu_ready); end
        n_checks++; if (bus.rs_to_alu_rs1 !== 32'd10) begin n_errors++; $display("FAIL wk_rs1: got %h expected a", bus.rs_to_alu_rs1); end
        n_checks++; if (bus.rs_to_alu_rs2 !== 32'd1) begin n_errors++; $display("FAIL wk_rs2: got %h expected 1", bus.rs_to_alu_rs2); end
        n_checks++; if (bus.rs_to_alu_op !== c_OP_SUB) begin n_errors++; $display("FAIL wk_op: got %h expected %h", bus.rs_to_alu_op, c_OP_SUB); end
        n_checks++; if (bus.rs_to_alu_rob_index !== 4'd5) begin n_errors++; $display("FAIL wk_rob: got %h expected 5", bus.rs_to_alu_rob_index); end
        tick();
    endtask

    task automatic test_dual_wakeup;
        drive_dispatch(c_OP_ADD, 32'h0, 32'h0, 1'b1, 4'd1, 1'b1, 4'd2, 32'h0, 32'h408, 4'd4);
        tick();
        idle();
        bus.alu_ready = 1'b1; bus.alu_rob_index = 4'd1; bus.alu_result = 32'h100;
        bus.lsb_ready = 1'b1; bus.lsb_rob_index = 4'd2; bus.lsb_result = 32'h200;
        tick();
        idle();
        tick();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b1) begin n_errors++; $display("FAIL dual_ready: got %b expected 1", bus.rs_to_alu_ready); end
        n_checks++; if (bus.rs_to_alu_rs1 !== 32'h100) begin n_errors++; $display("FAIL dual_rs1: got %h expected 100", bus.rs_to_alu_rs1); end
        n_checks++; if (bus.rs_to_alu_rs2 !== 32'h200) begin n_errors++; $display("FAIL dual_rs2: got %h expected 200", bus.rs_to_alu_rs2); end
        tick();
    endtask

    task automatic test_forward;
        drive_dispatch(c_OP_ADD, 32'd3, 32'h0, 1'b0, 4'd0, 1'b1, 4'd4, 32'h0, 32'h40C, 4'd6);
        bus.lsb_ready = 1'b1; bus.lsb_rob_index = 4'd4; bus.lsb_result = 32'h55;
        tick();
        idle();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b0) begin n_errors++; $display("FAIL fwd_early: got %b expected 0", bus.rs_to_alu_ready); end
        tick();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b1) begin n_errors++; $display("FAIL fwd_ready: got %b expected 1", bus.rs_to_alu_ready); end
        n_checks++; if (bus.rs_to_alu_rs2 !== 32'h55) begin n_errors++; $display("FAIL fwd_rs2: got %h expected 55", bus.rs_to_alu_rs2); end
        n_checks++; if (bus.rs_to_alu_rs1 !== 32'd3) begin n_errors++; $display("FAIL fwd_rs1: got %h expected 3", bus.rs_to_alu_rs1); end
        tick();
    endtask

    task automatic test_back_to_back;
        drive_dispatch(c_OP_ADD, 32'd1, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 32'h500, 4'd1);
        tick();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_early: got %b expected 0", bus.rs_to_alu_ready); end
        drive_dispatch(c_OP_ADD, 32'd2, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 32'h504, 4'd2);
        tick();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b1 || bus.rs_to_alu_rob_index !== 4'd1) begin n_errors++; $display("FAIL b2b_first: got ready %b rob %h expected 1/1", bus.rs_to_alu_ready, bus.rs_to_alu_rob_index); end
        drive_dispatch(c_OP_ADD, 32'd3, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 32'h508, 4'd3);
        tick();
        idle();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b1 || bus.rs_to_alu_rob_index !== 4'd2) begin n_errors++; $display("FAIL b2b_second: got ready %b rob %h expected 1/2", bus.rs_to_alu_ready, bus.rs_to_alu_rob_index); end
        tick();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b1 || bus.rs_to_alu_rs1 !== 32'd3) begin n_errors++; $display("FAIL b2b_third: got ready %b rs1 %h expected 1/3", bus.rs_to_alu_ready, bus.rs_to_alu_rs1); end
        tick();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_done: got %b expected 0", bus.rs_to_alu_ready); end
    endtask

    task automatic test_full;
        n_checks++; if (bus.rs_full !== 1'b0) begin n_errors++; $display("FAIL full_start: got %b expected 0", bus.rs_full); end
        for (int i = 0; i < 16; i++) begin
            drive_dispatch(c_OP_ADD, 32'h0, 32'(i), 1'b1, 4'd9, 1'b0, 4'd0, 32'(i), 32'h1000 + 32'(4 * i), 4'(i));
            tick();
        end
        n_checks++; if (bus.rs_full !== 1'b1) begin n_errors++; $display("FAIL full_set: got %b expected 1", bus.rs_full); end
        drive_dispatch(c_OP_SUB, 32'hAAAA, 32'hBBBB, 1'b0, 4'd0, 1'b0, 4'd0, 32'hDEAD, 32'h2000, 4'd0);
        tick();
        idle();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b0) begin n_errors++; $display("FAIL full_17th_issued: got %b expected 0", bus.rs_to_alu_ready); end
        bus.alu_ready = 1'b1; bus.alu_rob_index = 4'd9; bus.alu_result = 32'h900;
        tick();
        idle();
        n_checks++; if (bus.rs_full !== 1'b1) begin n_errors++; $display("FAIL full_after_bcast: got %b expected 1", bus.rs_full); end
        for (int k = 0; k < 16; k++) begin
            tick();
            n_checks++;
            if (bus.rs_to_alu_ready !== 1'b1 || bus.rs_to_alu_rob_index !== 4'(k) ||
                bus.rs_to_alu_rs1 !== 32'h900 || bus.rs_to_alu_rs2 !== 32'(k) || bus.rs_to_alu_imm !== 32'(k)) begin
                n_errors++;
                $display("FAIL full_issue%0d: got ready %b rob %h rs1 %h rs2 %h imm %h expected 1 %h 900 %h %h",
                         k, bus.rs_to_alu_ready, bus.rs_to_alu_rob_index, bus.rs_to_alu_rs1,
                         bus.rs_to_alu_rs2, bus.rs_to_alu_imm, k, k, k);
            end
            if (k == 0) begin
                n_checks++; if (bus.rs_full !== 1'b0) begin n_errors++; $display("FAIL full_drop: got %b expected 0", bus.rs_full); end
            end
        end
        tick();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b0) begin n_errors++; $display("FAIL full_drained: got %b expected 0", bus.rs_to_alu_ready); end
    endtask

    task automatic test_flush;
        drive_dispatch(c_OP_ADD, 32'h0, 32'h1, 1'b1, 4'd1, 1'b0, 4'd0, 32'h0, 32'h600, 4'd10);
        tick();
        drive_dispatch(c_OP_ADD, 32'h0, 32'h2, 1'b1, 4'd2, 1'b0, 4'd0, 32'h0, 32'h604, 4'd11);
        tick();
        drive_dispatch(c_OP_ADD, 32'h3, 32'h0, 1'b0, 4'd0, 1'b1, 4'd3, 32'h0, 32'h608, 4'd12);
        tick();
        drive_dispatch(c_OP_SUB, 32'h7, 32'h7, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 32'h60C, 4'd7);
        tick();
        idle();
        clr_in = 1'b1;
        tick();
        clr_in = 1'b0;
        n_checks++; if (bus.rs_to_alu_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b expected 0", bus.rs_to_alu_ready); end
        n_checks++; if (bus.rs_full !== 1'b0) begin n_errors++; $display("FAIL flush_full: got %b expected 0", bus.rs_full); end
        n_checks++; if (bus.rs_to_alu_rob_index !== 4'd0) begin n_errors++; $display("FAIL flush_rob: got %h expected 0", bus.rs_to_alu_rob_index); end
        n_checks++; if (bus.rs_to_alu_rs1 !== 32'h0) begin n_errors++; $display("FAIL flush_rs1: got %h expected 0", bus.rs_to_alu_rs1); end
        bus.alu_ready = 1'b1; bus.alu_rob_index = 4'd1; bus.alu_result = 32'h11;
        bus.lsb_ready = 1'b1; bus.lsb_rob_index = 4'd2; bus.lsb_result = 32'h22;
        tick();
        idle();
        bus.alu_ready = 1'b1; bus.alu_rob_index = 4'd3; bus.alu_result = 32'h33;
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (bus.rs_to_alu_ready !== 1'b0) begin n_errors++; $display("FAIL flush_stale%0d: got %b expected 0", k, bus.rs_to_alu_ready); end
            tick();
        end
    endtask

    task automatic test_stall;
        drive_dispatch(c_OP_ADD, 32'h44, 32'h5, 1'b0, 4'd0, 1'b1, 4'd12, 32'h0, 32'h700, 4'd9);
        tick();
        drive_dispatch(c_OP_ADD, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 32'h704, 4'd8);
        tick();
        idle();
        rdy_in = 1'b0;
        bus.alu_ready = 1'b1; bus.alu_rob_index = 4'd12; bus.alu_result = 32'h77;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++; if (bus.rs_to_alu_ready !== 1'b0) begin n_errors++; $display("FAIL stall_issue%0d: got %b expected 0", k, bus.rs_to_alu_ready); end
            n_checks++; if (bus.rs_to_alu_rob_index !== 4'd0) begin n_errors++; $display("FAIL stall_hold%0d: got %h expected 0", k, bus.rs_to_alu_rob_index); end
        end
        idle();
        rdy_in = 1'b1;
        tick();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b1 || bus.rs_to_alu_rob_index !== 4'd8) begin n_errors++; $display("FAIL stall_resume: got ready %b rob %h expected 1/8", bus.rs_to_alu_ready, bus.rs_to_alu_rob_index); end
        n_checks++; if (bus.rs_to_alu_rs1 !== 32'h11) begin n_errors++; $display("FAIL stall_rs1: got %h expected 11", bus.rs_to_alu_rs1); end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++; if (bus.rs_to_alu_ready !== 1'b0) begin n_errors++; $display("FAIL stall_pending%0d: got %b expected 0", k, bus.rs_to_alu_ready); end
        end
        bus.lsb_ready = 1'b1; bus.lsb_rob_index = 4'd12; bus.lsb_result = 32'h99;
        tick();
        idle();
        tick();
        n_checks++; if (bus.rs_to_alu_ready !== 1'b1 || bus.rs_to_alu_rob_index !== 4'd9) begin n_errors++; $display("FAIL stall_late: got ready %b rob %h expected 1/9", bus.rs_to_alu_ready, bus.rs_to_alu_rob_index); end
        n_checks++; if (bus.rs_to_alu_rs2 !== 32'h99) begin n_errors++; $display("FAIL stall_rs2: got %h expected 99", bus.rs_to_alu_rs2); end
    endtask

    initial begin
        idle();
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_dual_wakeup();
        test_forward();
        test_back_to_back();
        test_full();
        test_flush();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs.md
# rs

Reservation station for the integer ALU in the out-of-order RISC-V core. It buffers dispatched ALU and branch instructions until both source operands are available, capturing operands from the common data bus (CDB). Each cycle it issues at most one ready instruction into the ALU through the `rs_to_alu_*` registered handshake. It sits between the dispatch stage, upstream, and the ALU, downstream.

## Interface
- `RS_SIZE`, 16: number of entries; must be a power of two.
- `RS_WIDTH`, 4: log2(`RS_SIZE`).
- `clk_in` input 1: the block's single clock.
- `rst_in` input 1: reset; synchronous, active-high.
- `rdy_in` input 1: global ready; when low, all state holds.
- `clr_in` input 1: misprediction flush; synchronous, same effect as reset.
- `dispatch_valid` input 1: new instruction offered this cycle.
- `dispatch_op` input `OPENUM_TYPE`: operation enum.
- `dispatch_vj`, `dispatch_vk` input `DATA_TYPE`: operand values.
- `dispatch_qj_busy`, `dispatch_qk_busy` input 1: operand still pending.
- `dispatch_qj`, `dispatch_qk` input `ROB_INDEX_TYPE`: producer ROB tag of each pending operand.
- `dispatch_imm` input `DATA_TYPE`; `dispatch_PC` input `ADDR_TYPE`; `dispatch_rob_index` input `ROB_INDEX_TYPE`.
- `rs_full` output 1: combinational; high when all entries are busy.
- `alu_ready` input 1, `alu_result` input `DATA_TYPE`, `alu_rob_index` input `ROB_INDEX_TYPE`: CDB port 0 (ALU result).
- `lsb_ready` input 1, `lsb_result` input `DATA_TYPE`, `lsb_rob_index` input `ROB_INDEX_TYPE`: CDB port 1 (load/store buffer result).
- `rs_to_alu_ready` output 1: issue valid; a one-cycle pulse per instruction.
- `rs_to_alu_op`, `rs_to_alu_rs1`, `rs_to_alu_rs2`, `rs_to_alu_imm`, `rs_to_alu_PC`, `rs_to_alu_rob_index` outputs: registered issue payload.

## Operation
- Per-entry state: `busy`, `op`, `vj`, `vk`, `qj_busy`, `qk_busy`, `qj`, `qk`, `imm`, `PC`, `rob_index`.
- An entry is ready when `busy` is set and both `qj_busy` and `qk_busy` are clear.

Dispatch:
- When `dispatch_valid` is high and `rs_full` is low, the instruction is written into the lowest-index free entry.
- `dispatch_valid` while `rs_full` is high is ignored. The dispatcher is responsible for not doing this.

Dispatch-time forwarding:
- If a dispatched operand is pending and its tag equals a CDB tag valid in the same cycle, the entry stores the CDB value with the operand marked not pending.

Wakeup:
- Each cycle, every busy entry whose pending `qj` or `qk` matches `alu_rob_index` (while `alu_ready` is high) or `lsb_rob_index` (while `lsb_ready` is high) captures the broadcast value and clears the pending bit.
- Both CDB ports are compared independently, so `qj` and `qk` may wake from different ports in the same cycle.
- If both ports carry the same tag, the ALU port takes priority. This case is illegal, but the priority is still defined.

Issue:
- Select the lowest-index ready entry.
- Copy `vj` to `rs1`, `vk` to `rs2`, and `op`/`imm`/`PC`/`rob_index` into the output registers.
- Assert `rs_to_alu_ready` and clear that entry's `busy`.
- When no entry is ready, `rs_to_alu_ready` is 0 and the payload registers hold their previous values.
- Dispatch and issue in the same cycle always target different entries. An issued entry becomes free for dispatch from the next cycle.

Flush and reset:
- `rst_in` or `clr_in` clears every `busy` bit.
- It also sets `rs_to_alu_ready` and all `rs_to_alu_*` payload outputs to 0.
- It takes priority over dispatch, wakeup and issue in the same cycle.

Stall:
- With `rdy_in` low, nothing changes: no dispatch, no wakeup, no issue, and outputs hold.
- CDB broadcasts during a stall are not captured; upstream stalls with them.

## Timing
- All state is updated on the rising edge of `clk_in`; `rs_full` is the only combinational output.
- Dispatch sampled at edge E: the entry is visible after E and can issue at the earliest on edge E+1, with `rs_to_alu_ready` high in the cycle after E+1.
- A CDB broadcast sampled at edge E (at dispatch or via wakeup) makes the operand usable for issue at edge E+1.
- Back-to-back issue is allowed: one instruction per cycle while ready entries exist.
- `rs_full` reflects the busy vector after the last edge. An issue on edge E frees the slot, and `rs_full` drops after E.
- Reset value of every output is 0.

## Test plan
- Ready dispatch: after reset, dispatch ADD with vj=5, vk=7, no pending operands, rob=3. Exactly one-cycle `rs_to_alu_ready` one edge after dispatch, with rs1=5, rs2=7, op=ADD, rob_index=3.
- Wakeup: dispatch SUB with qj pending on tag 2 and vk=1. Pulse `alu_ready` with rob=2, result=10. Issue follows on the next edge with rs1=10, rs2=1; no issue before the broadcast.
- Dispatch-time forward: dispatch with qk pending on tag 4 in the same cycle `lsb_ready`/rob=4/result=0x55. Issue occurs the next edge with rs2=0x55.
- Full: fill 16 entries, all pending on tag 9. `rs_full`=1 and a 17th dispatch is ignored. Broadcast tag 9 on `alu_ready`. The 16 entries then issue in index order over 16 consecutive cycles, and `rs_full` drops after the first issue.
- Flush mid-operation: with 3 entries waiting and one issue pending, assert `clr_in` for one cycle. Next cycle `rs_to_alu_ready`=0 and `rs_full`=0, and a later broadcast of the old tags produces no issue.
- Stall: hold `rdy_in`=0 while a ready entry exists and a CDB broadcast occurs. No issue and no capture; after `rdy_in` returns to 1, the ready entry issues and the waiting entry stays pending.
